// File: rtl/mips_mc_pkg.sv
//============================================================================
// Module : mips_mc_pkg
// Brief  : Shared constants for the multi-cycle MIPS control FSM: state
//          encoding, opcodes, datapath mux encodings, legality helper.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package mips_mc_pkg;

    // FSM state encoding (4-bit, also exported on state_o)
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_REX    = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BEQ    = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;

    // Supported opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // ALU B operand select
    localparam logic [1:0] ALUB_REGB   = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMMSH2 = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode this controller knows how to sequence
    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mc_ctrl_if.sv
//============================================================================
// Module : mips_mc_ctrl_if
// Brief  : Controller <-> datapath signal bundle. master = controller side,
//          slave = datapath side. Counter signals exist only when
//          MC_CTRL_PERF_EN is defined.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface mips_mc_ctrl_if #(
    parameter int OP_W = 6
`ifdef MC_CTRL_PERF_EN
   ,parameter int CNT_W = 32
`endif
);
    logic [OP_W-1:0] opcode;
    logic            mem_ready;
    logic            pc_write;
    logic            branch;
    logic            iord;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [1:0]      pc_src;
    logic            illegal_op;
    logic [3:0]      state_o;
`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;
`endif

    modport master (
        input  opcode, mem_ready,
        output pc_write, branch, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal_op, state_o
`ifdef MC_CTRL_PERF_EN
              ,instr_count, cycle_count
`endif
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, branch, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal_op, state_o
`ifdef MC_CTRL_PERF_EN
              ,instr_count, cycle_count
`endif
    );

endinterface

`default_nettype wire

// File: rtl/mips_mc_outdec.sv
//============================================================================
// Module : mips_mc_outdec
// Brief  : Combinational state-to-control decode. Only ir_write/pc_write in
//          FETCH (gated by mem_ready) and illegal_op in DECODE look at inputs.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module mips_mc_outdec
    import mips_mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       op_legal,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op
);

    // Per-state control word; everything defaults low (IDLE and unused codes)
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_REGB;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                // IR and PC+4 commit only in the cycle the read completes
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = ALUB_IMMSH2;
                illegal_op = ~op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
//============================================================================
// Module : mips_mc_ctrl
// Brief  : Multi-cycle MIPS control FSM: state register, next-state logic,
//          and optional performance counters (MC_CTRL_PERF_EN).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int OP_W = 6
`ifdef MC_CTRL_PERF_EN
   ,parameter int CNT_W = 32
`endif
)(
    input  logic           clk,
    input  logic           rst,
    mips_mc_ctrl_if.master bus
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       op_legal;

    assign op_legal    = op_is_legal(bus.opcode);
    assign bus.state_o = state_q;

    // Next-state: memory states hold until mem_ready, DECODE dispatches on opcode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_REX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_REX:    state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BEQ, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register; async reset forces IDLE so all enables drop at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    mips_mc_outdec u_outdec (
        .state      (state_q),
        .mem_ready  (bus.mem_ready),
        .op_legal   (op_legal),
        .pc_write   (bus.pc_write),
        .branch     (bus.branch),
        .iord       (bus.iord),
        .mem_read   (bus.mem_read),
        .mem_write  (bus.mem_write),
        .ir_write   (bus.ir_write),
        .reg_dst    (bus.reg_dst),
        .mem_to_reg (bus.mem_to_reg),
        .reg_write  (bus.reg_write),
        .alu_src_a  (bus.alu_src_a),
        .alu_src_b  (bus.alu_src_b),
        .alu_op     (bus.alu_op),
        .pc_src     (bus.pc_src),
        .illegal_op (bus.illegal_op)
    );

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] instr_count_q;
    logic [CNT_W-1:0] instr_count_d;
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;
    logic             retire;

    // An instruction retires when a final state hands back to FETCH
    always_comb begin
        case (state_q)
            S_MEMWB, S_RWB, S_BEQ, S_ADDIWB, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = bus.mem_ready;
            default: retire = 1'b0;
        endcase
        instr_count_d = retire ? instr_count_q + CNT_W'(1) : instr_count_q;
        cycle_count_d = (state_q != S_IDLE) ? cycle_count_q + CNT_W'(1) : cycle_count_q;
    end

    // Free-running counters, wrap naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count_q <= '0;
            cycle_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.instr_count = instr_count_q;
    assign bus.cycle_count = cycle_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
//============================================================================
// Module : tb_mips_mc_ctrl
// Brief  : Self-checking bench for mips_mc_ctrl. Each instruction is expanded
//          into an expected per-cycle control trace from the opcode, the
//          number of FETCH wait cycles and the number of memory wait cycles.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_mips_mc_ctrl;
    import mips_mc_pkg::*;

    typedef struct packed {
        logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       illegal_op;
    } ctl_t;

    typedef struct packed {
        ctl_t       c;
        logic [3:0] st;
        logic       mr;
        logic       retire;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    step_t       seq[$];
    logic [5:0]  cur_op;
    int unsigned instr_m;
    int unsigned cyc_m;

    function automatic ctl_t obs();
        ctl_t o;
        o.pc_write   = bus.pc_write;   o.branch     = bus.branch;
        o.iord       = bus.iord;       o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;  o.ir_write   = bus.ir_write;
        o.reg_dst    = bus.reg_dst;    o.mem_to_reg = bus.mem_to_reg;
        o.reg_write  = bus.reg_write;  o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;  o.alu_op     = bus.alu_op;
        o.pc_src     = bus.pc_src;     o.illegal_op = bus.illegal_op;
        return o;
    endfunction

    function automatic logic known_op(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    endfunction

    task automatic push(input ctl_t c, input logic [3:0] st, input logic mr, input logic ret);
        step_t s;
        s.c = c; s.st = st; s.mr = mr; s.retire = ret;
        seq.push_back(s);
    endtask

    // Expected cycle-by-cycle trace of one instruction, FETCH through last state
    task automatic build_seq(input logic [5:0] op, input int fw, input int mw);
        ctl_t c;
        logic is_lw;
        seq.delete();
        cur_op = op;
        is_lw  = (op == 6'h23);
        for (int i = 0; i < fw; i++) begin
            c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
            push(c, S_FETCH, 1'b0, 1'b0);
        end
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1;
        push(c, S_FETCH, 1'b1, 1'b0);
        c = '0; c.alu_src_b = 2'b11; c.illegal_op = ~known_op(op);
        push(c, S_DECODE, 1'($urandom_range(0, 1)), 1'b0);
        case (op)
            6'h23, 6'h2B: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                push(c, S_MEMADR, 1'($urandom_range(0, 1)), 1'b0);
                c = '0; c.iord = 1'b1; c.mem_read = is_lw; c.mem_write = ~is_lw;
                for (int i = 0; i < mw; i++) push(c, is_lw ? S_MEMRD : S_MEMWR, 1'b0, 1'b0);
                push(c, is_lw ? S_MEMRD : S_MEMWR, 1'b1, ~is_lw);
                if (is_lw) begin
                    c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                    push(c, S_MEMWB, 1'($urandom_range(0, 1)), 1'b1);
                end
            end
            6'h00: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b10;
                push(c, S_REX, 1'($urandom_range(0, 1)), 1'b0);
                c = '0; c.reg_dst = 1'b1; c.reg_write = 1'b1;
                push(c, S_RWB, 1'($urandom_range(0, 1)), 1'b1);
            end
            6'h04: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.branch = 1'b1; c.pc_src = 2'b01;
                push(c, S_BEQ, 1'($urandom_range(0, 1)), 1'b1);
            end
            6'h08: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                push(c, S_ADDIEX, 1'($urandom_range(0, 1)), 1'b0);
                c = '0; c.reg_write = 1'b1;
                push(c, S_ADDIWB, 1'($urandom_range(0, 1)), 1'b1);
            end
            6'h02: begin
                c = '0; c.pc_write = 1'b1; c.pc_src = 2'b10;
                push(c, S_JUMP, 1'($urandom_range(0, 1)), 1'b1);
            end
            default: ;
        endcase
    endtask

    // One cycle: drive inputs just after the edge, sample 1 ns later, then advance
    task automatic exec_step(input step_t s);
        bus.mem_ready = s.mr;
        bus.opcode    = cur_op;
        #1;
        checks++;
        if (obs() !== s.c) begin
            errors++;
            $display("FAIL ctl op=%h st=%0d: got %h expected %h", cur_op, s.st, obs(), s.c);
        end
        checks++;
        if (bus.state_o !== s.st) begin
            errors++;
            $display("FAIL state op=%h: got %0d expected %0d", cur_op, bus.state_o, s.st);
        end
        checks++;
        if (((bus.mem_read & bus.mem_write) | (bus.reg_write & bus.mem_write)) !== 1'b0) begin
            errors++;
            $display("FAIL excl op=%h: got rd=%b wr=%b rw=%b expected no overlap",
                     cur_op, bus.mem_read, bus.mem_write, bus.reg_write);
        end
`ifdef MC_CTRL_PERF_EN
        checks++;
        if (bus.instr_count !== instr_m) begin
            errors++;
            $display("FAIL instr_count: got %0d expected %0d", bus.instr_count, instr_m);
        end
        checks++;
        if (bus.cycle_count !== cyc_m) begin
            errors++;
            $display("FAIL cycle_count: got %0d expected %0d", bus.cycle_count, cyc_m);
        end
`endif
        @(posedge clk);
        #1;
        cyc_m++;
        if (s.retire) instr_m++;
    endtask

    task automatic run_seq();
        while (seq.size() > 0) exec_step(seq.pop_front());
        checks++;
        if (bus.state_o !== S_FETCH) begin
            errors++;
            $display("FAIL return_fetch op=%h: got %0d expected %0d", cur_op, bus.state_o, S_FETCH);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'h00;
        instr_m = 0;
        cyc_m   = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs() !== ctl_t'(0)) begin
                errors++;
                $display("FAIL reset_ctl: got %h expected 0", obs());
            end
            checks++;
            if (bus.state_o !== S_IDLE) begin
                errors++;
                $display("FAIL reset_state: got %0d expected %0d", bus.state_o, S_IDLE);
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.state_o !== S_FETCH) begin
            errors++;
            $display("FAIL first_fetch: got %0d expected %0d", bus.state_o, S_FETCH);
        end
        checks++;
        if (bus.mem_read !== 1'b1) begin
            errors++;
            $display("FAIL first_fetch_rd: got %b expected 1", bus.mem_read);
        end
    endtask

    task automatic test_lw();          build_seq(6'h23, 0, 0); run_seq(); endtask
    task automatic test_sw_stall();    build_seq(6'h2B, 0, 2); run_seq(); endtask
    task automatic test_fetch_stall(); build_seq(6'h08, 3, 0); run_seq(); endtask
    task automatic test_illegal();     build_seq(6'h3F, 0, 0); run_seq(); endtask

    task automatic test_branch_jump();
        build_seq(6'h04, 0, 0); run_seq();
        build_seq(6'h02, 1, 0); run_seq();
        build_seq(6'h00, 0, 0); run_seq();
        build_seq(6'h23, 1, 2); run_seq();
    endtask

    task automatic test_mid_reset();
        step_t s;
        build_seq(6'h00, 0, 0);
        for (int i = 0; i < 3; i++) exec_step(seq.pop_front());
        s = seq.pop_front();
        bus.mem_ready = s.mr;
        #1;
        checks++;
        if (bus.reg_write !== 1'b1) begin
            errors++;
            $display("FAIL rwb_write: got %b expected 1", bus.reg_write);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.reg_write !== 1'b0) begin
            errors++;
            $display("FAIL abort_write: got %b expected 0", bus.reg_write);
        end
        checks++;
        if (bus.state_o !== S_IDLE) begin
            errors++;
            $display("FAIL abort_state: got %0d expected %0d", bus.state_o, S_IDLE);
        end
`ifdef MC_CTRL_PERF_EN
        checks++;
        if ((bus.instr_count | bus.cycle_count) !== '0) begin
            errors++;
            $display("FAIL abort_counters: got %0d/%0d expected 0/0", bus.instr_count, bus.cycle_count);
        end
`endif
        instr_m = 0;
        cyc_m   = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.state_o !== S_FETCH) begin
            errors++;
            $display("FAIL restart: got %0d expected %0d", bus.state_o, S_FETCH);
        end
    endtask

    task automatic test_random();
        logic [5:0] op;
        logic [5:0] ops [6];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        for (int n = 0; n < 60; n++) begin
            int pick;
            pick = int'($urandom_range(0, 6));
            if (pick < 6) begin
                op = ops[pick];
            end else begin
                op = 6'($urandom);
                while (known_op(op)) op = 6'($urandom);
            end
            build_seq(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            run_seq();
        end
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_fetch_stall();
        test_illegal();
        test_branch_jump();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
